// File: rtl/biquad_pkg.sv
`default_nettype none
// ============================================================================
// biquad_pkg : FSM encoding, config field layout and Q-format helpers
// Revision 1.0
// ============================================================================
package biquad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_WB   = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Coefficient term order inside one section and inside config_data.
  localparam int T_B0      = 0;
  localparam int T_B1      = 1;
  localparam int T_B2      = 2;
  localparam int T_A1      = 3;
  localparam int T_A2      = 4;
  localparam int NUM_TERMS = 5;
  localparam int FIELD_W   = 32;
  localparam int FIELD_END = NUM_TERMS * FIELD_W;

  function automatic int field_off(input int term);
    return term * FIELD_W;
  endfunction

  function automatic logic signed [127:0] q_one(input int frac);
    return 128'sd1 <<< frac;
  endfunction

  function automatic logic signed [127:0] q_round(input int frac);
    return 128'sd1 <<< (frac - 1);
  endfunction

  function automatic logic signed [127:0] sat_max(input int width);
    return (128'sd1 <<< (width - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [127:0] sat_min(input int width);
    return -(128'sd1 <<< (width - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_biquad_cascade_tdm_mac.sv
`default_nettype none
// ============================================================================
// biquad_mac : shared multiplier/accumulator with round-half-up and saturate
// Revision 1.0
// ============================================================================
module biquad_mac
  import biquad_pkg::*;
#(
  parameter int IW  = 32,
  parameter int CW  = 32,
  parameter int CDW = 30,
  parameter int GB  = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 en,
  input  logic                 clear,
  input  logic                 sub,
  input  logic signed [IW-1:0] sample,
  input  logic signed [CW-1:0] coef,
  output logic        [IW-1:0] y,
  output logic                 sat
);

  localparam int AW = IW + CW + GB;
  localparam logic signed [AW-1:0] C_RND = AW'(q_round(CDW));
  localparam logic signed [AW-1:0] C_HI  = AW'(sat_max(IW));
  localparam logic signed [AW-1:0] C_LO  = AW'(sat_min(IW));

  logic signed [IW+CW-1:0] w_prod;
  logic signed [AW-1:0]    w_prod_ext;
  logic signed [AW-1:0]    w_addend;
  logic signed [AW-1:0]    w_rnd;
  logic signed [AW-1:0]    w_sh;
  logic signed [AW-1:0]    r_acc;
  logic                    w_hi;
  logic                    w_lo;

  assign w_prod     = $signed({{CW{sample[IW-1]}}, sample}) * $signed({{IW{coef[CW-1]}}, coef});
  assign w_prod_ext = $signed({{GB{w_prod[IW+CW-1]}}, w_prod});
  assign w_addend   = sub ? -w_prod_ext : w_prod_ext;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= clear ? w_addend : r_acc + w_addend;
    end
  end

  assign w_rnd = r_acc + C_RND;
  assign w_sh  = w_rnd >>> CDW;
  assign w_hi  = (w_sh > C_HI);
  assign w_lo  = (w_sh < C_LO);
  assign sat   = w_hi | w_lo;
  assign y     = w_hi ? C_HI[IW-1:0] : (w_lo ? C_LO[IW-1:0] : w_sh[IW-1:0]);

endmodule
`default_nettype wire

// File: rtl/axis_biquad_cascade_tdm.sv
`default_nettype none
// ============================================================================
// axis_biquad_cascade_tdm : NSEC DF-1 biquads sharing one MAC, double-buffered
// coefficients applied only between samples.  Revision 1.0
// ============================================================================
module axis_biquad_cascade_tdm
  import biquad_pkg::*;
#(
  parameter int NSEC                      = 4,
  parameter int inout_width               = 32,
  parameter int inout_decimal_width       = 31,
  parameter int coefficient_width         = 32,
  parameter int coefficient_decimal_width = 30,
  parameter int guard_bits                = 4,
  parameter int configuration_address     = 999
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [31:0]            config_addr,
  input  logic [511:0]           config_data,
  input  logic [inout_width-1:0] S_AXIS_tdata,
  input  logic                   S_AXIS_tvalid,
  output logic                   S_AXIS_tready,
  output logic [inout_width-1:0] M_AXIS_tdata,
  output logic                   M_AXIS_tvalid,
  output logic                   sat_flag
);

  localparam int IW = inout_width;
  localparam int CW = coefficient_width;
  localparam int SW = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam logic signed [CW-1:0] C_UNITY = CW'(q_one(coefficient_decimal_width));
  localparam int C_FRAC_UNUSED = inout_decimal_width;

  state_t                r_state;
  logic [SW-1:0]         r_s;
  logic [2:0]            r_t;
  logic signed [IW-1:0]  r_x_in;
  logic signed [IW-1:0]  r_x1 [NSEC];
  logic signed [IW-1:0]  r_x2 [NSEC];
  logic signed [IW-1:0]  r_y1 [NSEC];
  logic signed [IW-1:0]  r_y2 [NSEC];
  logic signed [CW-1:0]  r_act [NSEC][NUM_TERMS];
  logic signed [CW-1:0]  r_shd [NSEC][NUM_TERMS];
  logic [NSEC-1:0]       r_pend;
  logic                  r_tready;
  logic                  r_mvalid;
  logic [IW-1:0]         r_mdata;
  logic                  r_sat;

  logic [NSEC-1:0]       w_wr;
  logic                  w_accept;
  logic                  w_apply;
  logic signed [IW-1:0]  w_op_x;
  logic signed [CW-1:0]  w_op_c;
  logic [IW-1:0]         w_y;
  logic                  w_sat;
  logic                  w_unused_cfg;

  assign w_unused_cfg = &{1'b0, config_data[511:FIELD_END], C_FRAC_UNUSED[0]};

  for (genvar k = 0; k < NSEC; k++) begin : g_cfg_dec
    assign w_wr[k] = (config_addr == 32'(configuration_address + k));
  end

  assign w_accept = (r_state == ST_IDLE) && S_AXIS_tvalid && r_tready;
  assign w_apply  = ((r_state == ST_IDLE) || (r_state == ST_OUT)) && (|r_pend);

  always_comb begin
    w_op_x = r_x_in;
    case (r_t)
      3'd1:    w_op_x = r_x1[r_s];
      3'd2:    w_op_x = r_x2[r_s];
      3'd3:    w_op_x = r_y1[r_s];
      3'd4:    w_op_x = r_y2[r_s];
      default: w_op_x = r_x_in;
    endcase
    w_op_c = r_act[r_s][r_t];
  end

  biquad_mac #(
    .IW  (IW),
    .CW  (CW),
    .CDW (coefficient_decimal_width),
    .GB  (guard_bits)
  ) u_mac (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (r_state == ST_MAC),
    .clear   (r_t == 3'd0),
    .sub     (r_t >= 3'(T_A1)),
    .sample  (w_op_x),
    .coef    (w_op_c),
    .y       (w_y),
    .sat     (w_sat)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= ST_IDLE;
      r_s      <= '0;
      r_t      <= '0;
      r_x_in   <= '0;
      r_pend   <= '0;
      r_tready <= 1'b0;
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
      r_sat    <= 1'b0;
      for (int k = 0; k < NSEC; k++) begin
        r_x1[k] <= '0;
        r_x2[k] <= '0;
        r_y1[k] <= '0;
        r_y2[k] <= '0;
        for (int j = 0; j < NUM_TERMS; j++) begin
          r_act[k][j] <= (j == T_B0) ? C_UNITY : '0;
          r_shd[k][j] <= (j == T_B0) ? C_UNITY : '0;
        end
      end
    end else begin
      r_mvalid <= 1'b0;

      for (int k = 0; k < NSEC; k++) begin
        if (w_wr[k]) begin
          for (int j = 0; j < NUM_TERMS; j++) begin
            r_shd[k][j] <= $signed(config_data[field_off(j) +: CW]);
          end
        end
      end
      r_pend <= (w_apply ? '0 : r_pend) | w_wr;

      // New coefficients never meet old filter history.
      if (w_apply) begin
        for (int k = 0; k < NSEC; k++) begin
          if (r_pend[k]) begin
            for (int j = 0; j < NUM_TERMS; j++) begin
              r_act[k][j] <= r_shd[k][j];
            end
          end
          r_x1[k] <= '0;
          r_x2[k] <= '0;
          r_y1[k] <= '0;
          r_y2[k] <= '0;
        end
      end

      if ((r_state == ST_WB) && w_sat) begin
        r_sat <= 1'b1;
      end else if (|w_wr) begin
        r_sat <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_tready <= 1'b1;
          if (w_accept) begin
            r_x_in   <= S_AXIS_tdata;
            r_s      <= '0;
            r_t      <= '0;
            r_tready <= 1'b0;
            r_state  <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (r_t == 3'(T_A2)) begin
            r_t     <= '0;
            r_state <= ST_WB;
          end else begin
            r_t <= r_t + 3'd1;
          end
        end
        ST_WB: begin
          r_x2[r_s] <= r_x1[r_s];
          r_x1[r_s] <= r_x_in;
          r_y2[r_s] <= r_y1[r_s];
          r_y1[r_s] <= w_y;
          r_x_in    <= w_y;
          if (r_s == SW'(NSEC - 1)) begin
            r_state <= ST_OUT;
          end else begin
            r_s     <= r_s + 1'b1;
            r_state <= ST_MAC;
          end
        end
        default: begin
          r_mdata  <= r_x_in;
          r_mvalid <= 1'b1;
          r_tready <= 1'b1;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign S_AXIS_tready = r_tready;
  assign M_AXIS_tdata  = r_mdata;
  assign M_AXIS_tvalid = r_mvalid;
  assign sat_flag      = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_axis_biquad_cascade_tdm.sv
`default_nettype none
// ============================================================================
// tb_axis_biquad_cascade_tdm : directed vector bench for the biquad cascade
// Revision 1.0
// ============================================================================
module tb_axis_biquad_cascade_tdm;

  localparam int NSEC   = 4;
  localparam int BASE   = 999;
  localparam int LAT    = 6 * NSEC + 1;
  localparam int PERIOD = 6 * NSEC + 2;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [31:0]  config_addr = '0;
  logic [511:0] config_data = '0;
  logic [31:0]  s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic         sat_flag;

  axis_biquad_cascade_tdm #(
    .NSEC                      (NSEC),
    .inout_width               (32),
    .inout_decimal_width       (31),
    .coefficient_width         (32),
    .coefficient_decimal_width (30),
    .guard_bits                (4),
    .configuration_address     (BASE)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .config_addr   (config_addr),
    .config_data   (config_data),
    .S_AXIS_tdata  (s_tdata),
    .S_AXIS_tvalid (s_tvalid),
    .S_AXIS_tready (s_tready),
    .M_AXIS_tdata  (m_tdata),
    .M_AXIS_tvalid (m_tvalid),
    .sat_flag      (sat_flag)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic            do_cfg;
    logic            all_sec;
    logic [4:0][31:0] c;
    logic [31:0]     x;
    logic [31:0]     y;
    logic            sat;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic write_cfg(input int k, input logic [4:0][31:0] c);
    config_addr = 32'(BASE + k);
    config_data = '0;
    for (int j = 0; j < 5; j++) config_data[32*j +: 32] = c[j];
    tick();
    config_addr = '0;
  endtask

  task automatic wait_out(input int start, output logic [31:0] y, output int lat);
    lat = 0;
    y   = '0;
    for (int n = start + 1; n <= start + 60; n++) begin
      tick();
      if (m_tvalid) begin
        lat = n;
        y   = m_tdata;
        break;
      end
    end
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!s_tready && w < 100) begin
      tick();
      w++;
    end
    check("tready_wait", s_tready, 1'b1);
  endtask

  task automatic send(input logic [31:0] x, output logic [31:0] y, output int lat);
    wait_ready();
    s_tdata  = x;
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    wait_out(0, y, lat);
  endtask

  function automatic vec_t mk(input logic cfg, input logic all,
                              input logic [31:0] b0, input logic [31:0] b1,
                              input logic [31:0] a1, input logic [31:0] x,
                              input logic [31:0] y, input logic sat);
    vec_t v;
    v.do_cfg  = cfg;
    v.all_sec = all;
    v.c       = {32'h0, a1, 32'h0, b1, b0};
    v.x       = x;
    v.y       = y;
    v.sat     = sat;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [11];
    logic [31:0] y;
    int          lat;
    logic [4:0][31:0] unity;
    logic [4:0][31:0] half;
    int          q [$];
    int          n_acc;
    int          n_out;
    int          last;
    logic        took;
    logic        seen;

    unity = {32'h0, 32'h0, 32'h0, 32'h0, 32'h4000_0000};
    half  = {32'h0, 32'h0, 32'h0, 32'h2000_0000, 32'h2000_0000};

    vecs[0]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h4000_0000, 32'h4000_0000, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 32'h2000_0000, 32'h2000_0000, 32'h0, 32'h4000_0000, 32'h2000_0000, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h2000_0000, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 32'h4000_0000, 32'h0, 32'hE000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h2000_0000, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1000_0000, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0800_0000, 1'b0);
    vecs[9]  = mk(1'b1, 1'b1, 32'h7C00_0000, 32'h0, 32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    vecs[10] = mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_0001, 32'h8000_0000, 1'b1);

    // Reset state
    repeat (3) tick();
    check("rst_tready", s_tready, 1'b0);
    check("rst_mvalid", m_tvalid, 1'b0);
    check("rst_mdata", m_tdata, 32'h0);
    check("rst_sat", sat_flag, 1'b0);
    aresetn = 1'b1;
    tick();
    check("post_rst_tready", s_tready, 1'b1);

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_cfg) begin
        for (int k = 0; k < (vecs[i].all_sec ? NSEC : 1); k++) write_cfg(k, vecs[i].c);
      end
      send(vecs[i].x, y, lat);
      check($sformatf("vec%0d_data", i), y, vecs[i].y);
      check($sformatf("vec%0d_lat", i), lat, LAT);
      check($sformatf("vec%0d_sat", i), sat_flag, vecs[i].sat);
    end

    // Config write clears the sticky flag; restore unity everywhere
    write_cfg(0, unity);
    check("sat_clear", sat_flag, 1'b0);
    for (int k = 1; k < NSEC; k++) write_cfg(k, unity);

    // Streaming with tvalid held high
    n_acc = 0;
    n_out = 0;
    last  = 0;
    s_tdata  = 32'd1;
    s_tvalid = 1'b1;
    for (int cyc = 1; cyc <= 400 && n_out < 5; cyc++) begin
      took = s_tvalid && s_tready;
      tick();
      if (took) begin
        if (n_acc > 0) check("tput_gap", cyc - last, PERIOD);
        last = cyc;
        q.push_back(int'(s_tdata));
        n_acc++;
        if (n_acc == 5) s_tvalid = 1'b0;
        else s_tdata = s_tdata + 32'd1;
      end
      if (m_tvalid) begin
        if (q.size() == 0) check("tput_extra", 1'b1, 1'b0);
        else check("tput_data", m_tdata, q.pop_front());
        n_out++;
      end
    end
    check("tput_count", n_out, 5);
    check("tput_first_in", 32'(n_acc), 5);

    // Config write in the middle of a computation
    wait_ready();
    s_tdata  = 32'h4000_0000;
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    repeat (4) tick();
    check("tready_busy", s_tready, 1'b0);
    repeat (5) tick();
    write_cfg(0, half);
    wait_out(10, y, lat);
    check("midcfg_old_coef", y, 32'h4000_0000);
    check("midcfg_lat", lat, LAT);
    send(32'h4000_0000, y, lat);
    check("midcfg_next_zero_state", y, 32'h2000_0000);

    // Reset asserted mid-computation
    wait_ready();
    s_tdata  = 32'h4000_0000;
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    repeat (8) tick();
    aresetn = 1'b0;
    #1;
    check("abort_tready", s_tready, 1'b0);
    check("abort_mvalid", m_tvalid, 1'b0);
    check("abort_mdata", m_tdata, 32'h0);
    check("abort_sat", sat_flag, 1'b0);
    repeat (3) tick();
    aresetn = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (m_tvalid) seen = 1'b1;
    end
    check("abort_no_valid", seen, 1'b0);
    send(32'h4000_0000, y, lat);
    check("abort_default_coef", y, 32'h4000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
